memory_dma_scheduler: RTL

- Descriptor queue and sequencer in front of memory_dma. It accepts {direction, address, length} descriptors from the CPU register block and splits each one into chunks of at most CHUNK_LENGTH bytes.
- For each chunk it issues one start pulse to memory_dma, waits for busy to rise and fall, then reports completion.
- Supports flush/abort and timeout recovery.

---
 rtl/memory_dma_pkg.sv | 29 ++
 rtl/memory_dma_descriptor_fifo.sv | 62 ++++++
 rtl/memory_dma_scheduler.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/memory_dma_pkg.sv
// Shared types for the memory_dma descriptor scheduler: descriptor layout,
// sequencer state encoding and address width.
package memory_dma_pkg;

   localparam int DMA_ADDRESS_WIDTH = 27;

   typedef struct packed {
      logic                         direction;
      logic [DMA_ADDRESS_WIDTH-1:0] address;
      logic [DMA_ADDRESS_WIDTH-1:0] length;
   } dma_descriptor_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_WAIT_BUSY,
      S_RUN,
      S_STOP
   } sched_state_t;

   function automatic logic [DMA_ADDRESS_WIDTH-1:0] chunk_size(
      input logic [DMA_ADDRESS_WIDTH-1:0] remaining,
      input logic [DMA_ADDRESS_WIDTH-1:0] limit
   );
      return (remaining < limit) ? remaining : limit;
   endfunction

endpackage

// File: rtl/memory_dma_descriptor_fifo.sv
// Synchronous descriptor FIFO with occupancy count, same-cycle push/pop and flush.
// Head entry is presented combinationally on pop_data (first-word fall-through).
module memory_dma_descriptor_fifo
   import memory_dma_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  dma_descriptor_t          push_data,
   output dma_descriptor_t          pop_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   dma_descriptor_t r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic            w_do_push;
   logic            w_do_pop;

   assign w_do_pop  = pop && (r_count != '0);
   assign w_do_push = push && ((r_count != CW'(DEPTH)) || w_do_pop);
   assign pop_data  = r_mem[r_rd_ptr];
   assign count     = r_count;

   // NOTE: storage is deliberately left without reset; only pointers and count
   // define validity, so clearing the array would buy nothing.
   always_ff @(posedge clk) begin
      if (w_do_push && !flush)
         r_mem[r_wr_ptr] <= push_data;
   end

   // NOTE: all sequential state uses non-blocking assignments so every register
   // sees the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/memory_dma_scheduler.sv
// Descriptor queue and chunking sequencer in front of memory_dma.
// Optional watchdog recovery enabled by defining DMA_SCHEDULER_TIMEOUT_EN.
module memory_dma_scheduler
   import memory_dma_pkg::*;
#(
   parameter int                           DEPTH        = 4,
   parameter logic [DMA_ADDRESS_WIDTH-1:0] CHUNK_LENGTH = 27'd4096
`ifdef DMA_SCHEDULER_TIMEOUT_EN
   , parameter int                         TIMEOUT_CYCLES = 1048576
`endif
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         push,
   output logic                         push_ready,
   input  logic                         push_direction,
   input  logic [DMA_ADDRESS_WIDTH-1:0] push_address,
   input  logic [DMA_ADDRESS_WIDTH-1:0] push_length,
   input  logic                         abort,
   output logic [$clog2(DEPTH):0]       queue_count,
   output logic                         active,
   output logic                         done,
   output logic                         error,
   output logic                         aborted,
`ifdef DMA_SCHEDULER_TIMEOUT_EN
   output logic                         timeout,
`endif
   output logic                         dma_start,
   output logic                         dma_stop,
   input  logic                         dma_busy,
   output logic                         dma_direction,
   output logic [DMA_ADDRESS_WIDTH-1:0] dma_starting_address,
   output logic [DMA_ADDRESS_WIDTH-1:0] dma_transfer_length
);

   localparam int QW = $clog2(DEPTH) + 1;

   sched_state_t                 r_state;
   logic                         r_cur_dir;
   logic [DMA_ADDRESS_WIDTH-1:0] r_cur_addr;
   logic [DMA_ADDRESS_WIDTH-1:0] r_cur_rem;
   logic                         r_dma_dir;
   logic [DMA_ADDRESS_WIDTH-1:0] r_dma_addr;
   logic [DMA_ADDRESS_WIDTH-1:0] r_dma_len;
   logic                         r_dma_start;
   logic                         r_dma_stop;
   logic                         r_done;
   logic                         r_error;
   logic                         r_aborted;

   dma_descriptor_t              w_push_desc;
   dma_descriptor_t              w_head;
   logic [QW-1:0]                w_count;
   logic                         w_abort_evt;
   logic                         w_pop;
   logic                         w_push_ok;
   logic                         w_push_store;
   logic                         w_push_zero;

`ifdef DMA_SCHEDULER_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] r_wd;
   logic            r_timeout;
   logic            w_wd_expired;

   // START is the first counted cycle, so expiry lands TIMEOUT_CYCLES after dma_start.
   assign w_wd_expired = ((r_state == S_WAIT_BUSY) || (r_state == S_RUN)) &&
                         (r_wd == WD_W'(TIMEOUT_CYCLES - 2));
   assign w_abort_evt  = abort || w_wd_expired;
   assign timeout      = r_timeout;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_wd <= '0;
      else if (r_state == S_START)
         r_wd <= '0;
      else if ((r_state == S_WAIT_BUSY) || (r_state == S_RUN))
         r_wd <= r_wd + 1'b1;
   end
`else
   assign w_abort_evt = abort;
`endif

   assign w_pop        = (r_state == S_IDLE) && (w_count != '0) && !w_abort_evt;
   assign push_ready   = ((w_count != QW'(DEPTH)) || w_pop) && !w_abort_evt;
   assign w_push_ok    = push && push_ready;
   assign w_push_zero  = w_push_ok && (push_length == '0);
   assign w_push_store = w_push_ok && (push_length != '0);
   assign w_push_desc  = '{direction: push_direction, address: push_address, length: push_length};

   memory_dma_descriptor_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (w_push_store),
      .pop       (w_pop),
      .flush     (w_abort_evt),
      .push_data (w_push_desc),
      .pop_data  (w_head),
      .count     (w_count)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_cur_dir   <= 1'b0;
         r_cur_addr  <= '0;
         r_cur_rem   <= '0;
         r_dma_dir   <= 1'b0;
         r_dma_addr  <= '0;
         r_dma_len   <= '0;
         r_dma_start <= 1'b0;
         r_dma_stop  <= 1'b0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
         r_aborted   <= 1'b0;
`ifdef DMA_SCHEDULER_TIMEOUT_EN
         r_timeout   <= 1'b0;
`endif
      end else begin
         r_dma_start <= 1'b0;
         r_dma_stop  <= 1'b0;
         r_done      <= 1'b0;
         r_aborted   <= 1'b0;
         r_error     <= w_push_zero;
`ifdef DMA_SCHEDULER_TIMEOUT_EN
         r_timeout   <= 1'b0;
`endif
         if (w_abort_evt) begin
            // Abort wins over every state transition, so done can never coincide with aborted.
            r_cur_rem <= '0;
            r_aborted <= 1'b1;
`ifdef DMA_SCHEDULER_TIMEOUT_EN
            r_timeout <= w_wd_expired;
`endif
            if (r_state != S_IDLE) begin
               r_state    <= S_STOP;
               r_dma_stop <= 1'b1;
            end
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_pop) begin
                     r_cur_dir  <= w_head.direction;
                     r_cur_addr <= w_head.address;
                     r_cur_rem  <= w_head.length;
                     r_state    <= S_LOAD;
                  end
               end
               S_LOAD: begin
                  r_dma_dir   <= r_cur_dir;
                  r_dma_addr  <= r_cur_addr;
                  r_dma_len   <= chunk_size(r_cur_rem, CHUNK_LENGTH);
                  r_dma_start <= 1'b1;
                  r_state     <= S_START;
               end
               S_START: begin
                  r_cur_addr <= r_cur_addr + r_dma_len;
                  r_cur_rem  <= r_cur_rem - r_dma_len;
                  r_state    <= S_WAIT_BUSY;
               end
               S_WAIT_BUSY: begin
                  if (dma_busy)
                     r_state <= S_RUN;
               end
               S_RUN: begin
                  if (!dma_busy) begin
                     if (r_cur_rem != '0) begin
                        r_state <= S_LOAD;
                     end else begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                     end
                  end
               end
               S_STOP:  r_state <= S_IDLE;
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign queue_count          = w_count;
   assign active               = (r_state != S_IDLE);
   assign done                 = r_done;
   assign error                = r_error;
   assign aborted              = r_aborted;
   assign dma_start            = r_dma_start;
   assign dma_stop             = r_dma_stop;
   assign dma_direction        = r_dma_dir;
   assign dma_starting_address = r_dma_addr;
   assign dma_transfer_length  = r_dma_len;

endmodule
